fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request at a time, redirect
// (trap over jump) with kill of in-flight responses, registered output stage.
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  input  logic        trap_flag,
  input  logic [31:0] trap_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t      state, state_nxt;
  logic        kill, kill_nxt;
  logic [31:0] pc_nxt;
  logic        capture, drop_valid;
  logic        redir;
  logic [31:0] target;

  assign redir     = trap_flag | jump_flag;
  assign target    = trap_flag ? trap_addr : jump_addr;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc_out;

  always_comb begin
    state_nxt  = state;
    kill_nxt   = kill;
    pc_nxt     = pc_out;
    capture    = 1'b0;
    drop_valid = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // A redirect coinciding with the grant still owes us a response,
        // so track it with kill and throw the data away on arrival.
        if (imem_gnt) begin
          state_nxt = RESP;
          kill_nxt  = redir;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          if (kill || redir) begin
            state_nxt = REQ;
            kill_nxt  = 1'b0;
          end else begin
            state_nxt = OUT;
            capture   = 1'b1;
          end
        end else if (redir) begin
          kill_nxt = 1'b1;
        end
      end
      OUT: begin
        if (redir || inst_ready) begin
          state_nxt  = REQ;
          drop_valid = 1'b1;
          if (!redir) pc_nxt = pc_out + 32'd4;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redir) pc_nxt = target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kill       <= 1'b0;
      pc_out     <= RESET_ADDR;
      inst_valid <= 1'b0;
      inst_out   <= NOP;
      inst_pc    <= RESET_ADDR;
    end else begin
      state  <= state_nxt;
      kill   <= kill_nxt;
      pc_out <= pc_nxt;
      if (capture) begin
        inst_valid <= 1'b1;
        inst_out   <= imem_rdata;
        inst_pc    <= pc_out;
      end else if (drop_valid) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule
